// File: rtl/uart_loader_pkg.sv
// uart_loader_pkg: shared types and constants for the UART program loader.
//   loader_state_t : frame FSM states
//   rx_state_t     : byte receiver states
//   SYNC_BYTE      : first byte of every frame
//   clks_per_bit() : clock cycles per serial bit
package uart_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Integer division; callers need a result of at least 4.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_loader_if.sv
// uart_loader_if: instruction RAM write port driven by the loader.
//   mem_addr : word address
//   mem_data : write data
//   mem_we   : one-cycle write strobe
// master = loader side, slave = RAM / mux side.
interface uart_loader_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic              mem_we;

  modport master (output mem_addr, output mem_data, output mem_we);
  modport slave  (input  mem_addr, input  mem_data, input  mem_we);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART byte receiver.
//   clk, rst_n  : clock, async active-low reset
//   rx          : serial input (asynchronous, idle high)
//   byte_data   : received byte, valid with byte_valid
//   byte_valid  : one-cycle pulse per good byte
//   frame_err   : one-cycle pulse when the stop bit samples low
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);
  import uart_loader_pkg::*;

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             rx_meta_r, rx_sync_r, rx_prev_r;
  rx_state_t        state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;

  // Two-flop synchronizer plus one delay stage for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Bit timing: half a bit to the start-bit centre, then full bits to each later centre.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= RX_IDLE;
      cnt_r      <= '0;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
      byte_data  <= 8'h00;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state_r)
        RX_IDLE: begin
          cnt_r <= '0;
          if (rx_prev_r && !rx_sync_r) begin
            state_r <= RX_START;
          end
        end
        RX_START: begin
          if (cnt_r == HALF_END) begin
            cnt_r     <= '0;
            bit_idx_r <= 3'd0;
            // A high line at the start-bit centre was only a glitch.
            state_r   <= rx_sync_r ? RX_IDLE : RX_DATA;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (cnt_r == BIT_END) begin
            cnt_r     <= '0;
            shift_r   <= {rx_sync_r, shift_r[7:1]};
            bit_idx_r <= bit_idx_r + 3'd1;
            if (bit_idx_r == 3'd7) begin
              state_r <= RX_STOP;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (cnt_r == BIT_END) begin
            cnt_r   <= '0;
            state_r <= RX_IDLE;
            if (rx_sync_r) begin
              byte_data  <= shift_r;
              byte_valid <= 1'b1;
            end else begin
              frame_err  <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: state_r <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_loader.sv
// uart_loader: fills the instruction RAM from a framed UART program image.
// Frame: A5, LEN_LO, LEN_HI, LEN x 4 data bytes (LSB first), CSUM (XOR after sync).
//   clk, rst_n : clock, async active-low reset
//   rx         : serial input
//   mem        : RAM write port (master modport)
//   core_hold  : core stalled while a load is running or the image is untrusted
//   load_done  : one-cycle pulse after a good frame
//   load_err   : sticky error, cleared by the next sync byte
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int ADDR_W       = 8,
  parameter int START_ADDR   = 0,
  parameter int TIMEOUT_BITS = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx,
  uart_loader_if.master    mem,
  output logic             core_hold,
  output logic             load_done,
  output logic             load_err
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_BITS * CLKS_PER_BIT);

  logic [7:0]        byte_data_s;
  logic              byte_valid_s, frame_err_s;
  logic              active_s, fault_s;

  loader_state_t     state_r;
  logic [15:0]       words_left_r;
  logic [1:0]        byte_idx_r;
  logic [31:0]       asm_r;
  logic [ADDR_W-1:0] ptr_r;
  logic [7:0]        csum_r;
  logic [31:0]       tmo_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [31:0]       mem_data_r;
  logic              mem_we_r;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .byte_data (byte_data_s),
    .byte_valid(byte_valid_s),
    .frame_err (frame_err_s)
  );

  assign active_s = (state_r == ST_LEN_LO) || (state_r == ST_LEN_HI) ||
                    (state_r == ST_DATA)   || (state_r == ST_CSUM);
  // A received byte always takes priority over a fault in the same cycle.
  assign fault_s  = !byte_valid_s && (frame_err_s || (tmo_r > TMO_LIMIT));

  assign mem.mem_addr = mem_addr_r;
  assign mem.mem_data = mem_data_r;
  assign mem.mem_we   = mem_we_r;

  // Inter-byte gap counter, running only while a frame is in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_r <= 32'd0;
    end else if (active_s && !byte_valid_s) begin
      tmo_r <= tmo_r + 32'd1;
    end else begin
      tmo_r <= 32'd0;
    end
  end

  // Frame FSM with word assembly, RAM write, checksum and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      words_left_r <= 16'd0;
      byte_idx_r   <= 2'd0;
      asm_r        <= 32'd0;
      ptr_r        <= '0;
      csum_r       <= 8'h00;
      mem_addr_r   <= '0;
      mem_data_r   <= 32'd0;
      mem_we_r     <= 1'b0;
      core_hold    <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      mem_we_r  <= 1'b0;
      load_done <= 1'b0;
      case (state_r)
        ST_IDLE, ST_ERR: begin
          if (byte_valid_s && (byte_data_s == SYNC_BYTE)) begin
            state_r   <= ST_LEN_LO;
            core_hold <= 1'b1;
            load_err  <= 1'b0;
            csum_r    <= 8'h00;
            ptr_r     <= ADDR_W'(START_ADDR);
          end
        end
        ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM: begin
          if (byte_valid_s) begin
            csum_r <= csum_r ^ byte_data_s;
            case (state_r)
              ST_LEN_LO: begin
                words_left_r[7:0] <= byte_data_s;
                state_r           <= ST_LEN_HI;
              end
              ST_LEN_HI: begin
                words_left_r[15:8] <= byte_data_s;
                byte_idx_r         <= 2'd0;
                state_r <= ({byte_data_s, words_left_r[7:0]} == 16'd0) ? ST_CSUM : ST_DATA;
              end
              ST_DATA: begin
                asm_r      <= {byte_data_s, asm_r[31:8]};
                byte_idx_r <= byte_idx_r + 2'd1;
                if (byte_idx_r == 2'd3) begin
                  mem_data_r   <= {byte_data_s, asm_r[31:8]};
                  mem_addr_r   <= ptr_r;
                  mem_we_r     <= 1'b1;
                  ptr_r        <= ptr_r + ADDR_W'(1);
                  words_left_r <= words_left_r - 16'd1;
                  if (words_left_r == 16'd1) begin
                    state_r <= ST_CSUM;
                  end
                end
              end
              ST_CSUM: begin
                if (byte_data_s == csum_r) begin
                  state_r   <= ST_DONE;
                  load_done <= 1'b1;
                  core_hold <= 1'b0;
                end else begin
                  state_r  <= ST_ERR;
                  load_err <= 1'b1;
                end
              end
              default: state_r <= ST_ERR;
            endcase
          end else if (fault_s) begin
            state_r  <= ST_ERR;
            load_err <= 1'b1;
          end
        end
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule
